accu_core_p: RTL and testbench
==============================

Name: accu_core_p

Overview:
- Parametrised next-generation accumulator processor core. Generalises the fixed 8-bit/6-bit single-cycle core in data width, PC width and register count.
- Adds features the current core lacks: a call/return stack, zero/carry conditional branches, HALT, and a stall-capable req/ack data-memory handshake.
- Program memory stays external and combinational. Data memory is external and may take any number of cycles.
- Sits where the current top-level datapath+control sits; the debug monitor taps pc/acc.

Parameters:
- DATA_W, 8, accumulator/register/data-memory word width; must be >= PC_W.
- PC_W, 6, program counter width; program memory depth is 2^PC_W.
- REG_N, 16, number of general registers, indexed by operand[$clog2(REG_N)-1:0].
- STACK_DEPTH, 4, return-address stack entries.
- INS_W, 5+DATA_W, instruction width: opcode = ins[INS_W-1 -: 5], operand = ins[DATA_W-1:0].

Ports:
- clk, input, 1, rising-edge clock.
- nReset, input, 1, synchronous active-low reset.
- pc, output, PC_W, program memory address.
- ins, input, INS_W, instruction at pc, combinational same cycle.
- dm_req, output, 1, data memory request, registered.
- dm_we, output, 1, 1 = write, valid while dm_req.
- dm_addr, output, DATA_W, memory address (operand).
- dm_wdata, output, DATA_W, write data (A at issue).
- dm_rdata, input, DATA_W, read data, valid when dm_ack.
- dm_ack, input, 1, one-cycle completion strobe.
- acc, output, DATA_W, accumulator value.
- flags, output, 2, {C,Z}.
- halted, output, 1, core in HALT state.
- err, output, 1, sticky stack overflow/underflow.

Behaviour:
- Reset (nReset=0 at clk edge) overrides everything, including mid-transaction:
  - pc=0, A=0, C=0, Z=0, all regs=0, stack pointer=0, dm_req=0, dm_we=0, dm_addr=0, dm_wdata=0, state=RUN, halted=0, err=0.
  - An outstanding dm_ack after reset is ignored.
- States:
  - RUN: one instruction per cycle; pc<=pc+1 (wraps 2^PC_W-1 -> 0) unless the instruction is a branch.
  - MEM_WAIT: pc, A, regs frozen; dm_* outputs held stable.
  - HALT: everything frozen; only reset leaves HALT.
- Opcodes:
  - 00 NOP.
  - 01 LDI: A=opnd.
  - 02 LDR: A=R[opnd].
  - 03 STR: R[opnd]=A.
  - 04 LDM: read memory. 05 STM: write memory.
  - 06 ADD: {C,A}=A+R.
  - 07 ADC: {C,A}=A+R+C.
  - 08 SUB: A=A-R, C=borrow (1 when A<R unsigned).
  - 09 AND, 0A OR, 0B XOR: A op R; C unchanged.
  - 0C ADDI: {C,A}=A+opnd.
  - 0D JMP: pc=opnd[PC_W-1:0].
  - 0E JZ: jump if Z. 0F JC: jump if C.
  - 10 CALL: push pc+1, jump.
  - 11 RET: pop into pc.
  - 12 HALT.
  - 13-1F: execute as NOP.
- Z is updated to (newA==0) by every instruction that writes A. C is updated only by ADD/ADC/SUB/ADDI. All arithmetic is modulo 2^DATA_W.
- Memory handshake:
  - LDM/STM in RUN: at the next edge dm_req=1, dm_we=(op==STM), dm_addr=opnd, dm_wdata=A; state=MEM_WAIT; pc not advanced.
  - In MEM_WAIT, at the first edge with dm_ack=1: LDM loads A=dm_rdata (Z updated); dm_req=0; pc=pc+1; state=RUN.
  - Minimum latency is 2 cycles (ack in the first cycle of req). The wait is unbounded.
  - dm_ack while dm_req=0 is ignored.
- Stack:
  - CALL with STACK_DEPTH entries already used, or RET with the stack empty: no push/pop, err=1, state=HALT, pc unchanged.
  - A CALL at pc=2^PC_W-1 pushes 0.
- halted=1 exactly in HALT. err stays 1 until reset.

Test Plan:
- Reset/ALU: LDI 0xF0; ADDI 0x20 -> A=0x10, C=1, Z=0. Then SUB with R0=0x10 -> A=0x00, Z=1, C=0. pc=3 after 3 cycles.
- Registers/ADC: LDI 0xFF; STR 5; ADDI 0x01 (C=1); ADC R5 -> A=0x00 (0x00+0xFF+1), C=1, Z=1.
- Memory stall: STM 0x12 with A=0x5A, ack held off 3 cycles -> dm_req=1, dm_we=1, dm_addr=0x12, dm_wdata=0x5A stable for 4 cycles; pc frozen. Then LDM 0x12 with ack+rdata=0x5A in the first cycle -> A=0x5A, exactly 2 cycles.
- Branches: JZ 0x20 with Z=0 -> pc+1; JC 0x20 with C=1 -> pc=0x20. pc wrap from 0x3F -> 0x00 on NOP.
- Stack: 4 nested CALLs then RET x4 -> returns in LIFO order. 5th CALL -> err=1, halted=1, pc holds. A RET on an empty stack after reset gives the same err/halt behaviour.
- Reset mid-op: assert nReset=0 during MEM_WAIT -> dm_req=0, pc=0, A=0 next edge. A stray dm_ack afterwards changes nothing. HALT opcode -> halted=1, pc frozen for 10 cycles.

Source files
------------

// File: rtl/accu_core_p.sv
// Parametrised accumulator core with a return-address stack, flag branches,
// HALT, and a stall-capable req/ack data-memory port.
module accu_core_p #(
    parameter int DATA_W      = 8,
    parameter int PC_W        = 6,
    parameter int REG_N       = 16,
    parameter int STACK_DEPTH = 4,
    parameter int INS_W       = 5 + DATA_W
) (
    input  logic              clk,
    input  logic              nReset,
    output logic [PC_W-1:0]   pc,
    input  logic [INS_W-1:0]  ins,
    output logic              dm_req,
    output logic              dm_we,
    output logic [DATA_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    input  logic [DATA_W-1:0] dm_rdata,
    input  logic              dm_ack,
    output logic [DATA_W-1:0] acc,
    output logic [1:0]        flags,
    output logic              halted,
    output logic              err
);

    localparam int RI_W = (REG_N > 1) ? $clog2(REG_N) : 1;
    localparam int SI_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int SP_W = $clog2(STACK_DEPTH + 1);
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_HALT     = 2'd2;

    localparam logic [4:0] OP_LDI  = 5'h01;
    localparam logic [4:0] OP_LDR  = 5'h02;
    localparam logic [4:0] OP_STR  = 5'h03;
    localparam logic [4:0] OP_LDM  = 5'h04;
    localparam logic [4:0] OP_STM  = 5'h05;
    localparam logic [4:0] OP_ADD  = 5'h06;
    localparam logic [4:0] OP_ADC  = 5'h07;
    localparam logic [4:0] OP_SUB  = 5'h08;
    localparam logic [4:0] OP_AND  = 5'h09;
    localparam logic [4:0] OP_OR   = 5'h0A;
    localparam logic [4:0] OP_XOR  = 5'h0B;
    localparam logic [4:0] OP_ADDI = 5'h0C;
    localparam logic [4:0] OP_JMP  = 5'h0D;
    localparam logic [4:0] OP_JZ   = 5'h0E;
    localparam logic [4:0] OP_JC   = 5'h0F;
    localparam logic [4:0] OP_CALL = 5'h10;
    localparam logic [4:0] OP_RET  = 5'h11;
    localparam logic [4:0] OP_HALT = 5'h12;

    logic [1:0]        state;
    logic [DATA_W-1:0] acc_r;
    logic              c_flag;
    logic              z_flag;
    logic [DATA_W-1:0] regs  [REG_N];
    logic [PC_W-1:0]   stack [STACK_DEPTH];
    logic [SP_W-1:0]   sp;

    logic [4:0]        op;
    logic [DATA_W-1:0] opnd;
    logic [RI_W-1:0]   rsel;
    logic [DATA_W-1:0] rval;
    logic [PC_W-1:0]   pc_inc;
    logic [PC_W-1:0]   target;
    logic [SI_W-1:0]   push_idx;
    logic [SI_W-1:0]   pop_idx;

    logic [DATA_W:0]   sum_add;
    logic [DATA_W:0]   sum_adc;
    logic [DATA_W:0]   sum_sub;
    logic [DATA_W:0]   sum_addi;
    logic [DATA_W:0]   c_ext;

    logic              a_wr;
    logic [DATA_W-1:0] a_new;
    logic              c_wr;
    logic              c_new;

    assign op       = ins[INS_W-1 -: 5];
    assign opnd     = ins[DATA_W-1:0];
    assign rsel     = opnd[RI_W-1:0];
    assign rval     = regs[rsel];
    assign pc_inc   = pc + PC_W'(1);
    assign target   = opnd[PC_W-1:0];
    assign push_idx = SI_W'(sp);
    assign pop_idx  = SI_W'(sp - SP_W'(1));

    assign c_ext    = {{DATA_W{1'b0}}, c_flag};
    assign sum_add  = {1'b0, acc_r} + {1'b0, rval};
    assign sum_adc  = sum_add + c_ext;
    // The extra top bit of the difference is the borrow (set when A < R).
    assign sum_sub  = {1'b0, acc_r} - {1'b0, rval};
    assign sum_addi = {1'b0, acc_r} + {1'b0, opnd};

    always_comb begin
        a_wr  = 1'b0;
        a_new = acc_r;
        c_wr  = 1'b0;
        c_new = c_flag;
        case (op)
            OP_LDI:  begin a_wr = 1'b1; a_new = opnd; end
            OP_LDR:  begin a_wr = 1'b1; a_new = rval; end
            OP_ADD:  begin a_wr = 1'b1; c_wr = 1'b1; {c_new, a_new} = sum_add; end
            OP_ADC:  begin a_wr = 1'b1; c_wr = 1'b1; {c_new, a_new} = sum_adc; end
            OP_SUB:  begin a_wr = 1'b1; c_wr = 1'b1; {c_new, a_new} = sum_sub; end
            OP_ADDI: begin a_wr = 1'b1; c_wr = 1'b1; {c_new, a_new} = sum_addi; end
            OP_AND:  begin a_wr = 1'b1; a_new = acc_r & rval; end
            OP_OR:   begin a_wr = 1'b1; a_new = acc_r | rval; end
            OP_XOR:  begin a_wr = 1'b1; a_new = acc_r ^ rval; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nReset) begin
            state    <= ST_RUN;
            pc       <= '0;
            acc_r    <= '0;
            c_flag   <= 1'b0;
            z_flag   <= 1'b0;
            sp       <= '0;
            dm_req   <= 1'b0;
            dm_we    <= 1'b0;
            dm_addr  <= '0;
            dm_wdata <= '0;
            err      <= 1'b0;
            for (int unsigned i = 0; i < REG_N; i++) regs[i] <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (a_wr) begin
                        acc_r  <= a_new;
                        z_flag <= (a_new == '0);
                    end
                    if (c_wr) c_flag <= c_new;
                    case (op)
                        OP_STR: begin
                            regs[rsel] <= acc_r;
                            pc         <= pc_inc;
                        end
                        OP_LDM, OP_STM: begin
                            dm_req   <= 1'b1;
                            dm_we    <= (op == OP_STM);
                            dm_addr  <= opnd;
                            dm_wdata <= acc_r;
                            state    <= ST_MEM_WAIT;
                        end
                        OP_JMP: pc <= target;
                        OP_JZ:  pc <= z_flag ? target : pc_inc;
                        OP_JC:  pc <= c_flag ? target : pc_inc;
                        OP_CALL: begin
                            if (sp == SP_FULL) begin
                                err   <= 1'b1;
                                state <= ST_HALT;
                            end else begin
                                stack[push_idx] <= pc_inc;
                                sp              <= sp + SP_W'(1);
                                pc              <= target;
                            end
                        end
                        OP_RET: begin
                            if (sp == '0) begin
                                err   <= 1'b1;
                                state <= ST_HALT;
                            end else begin
                                pc <= stack[pop_idx];
                                sp <= sp - SP_W'(1);
                            end
                        end
                        OP_HALT: state <= ST_HALT;
                        default: pc <= pc_inc;
                    endcase
                end
                ST_MEM_WAIT: begin
                    if (dm_ack) begin
                        if (!dm_we) begin
                            acc_r  <= dm_rdata;
                            z_flag <= (dm_rdata == '0);
                        end
                        dm_req <= 1'b0;
                        pc     <= pc_inc;
                        state  <= ST_RUN;
                    end
                end
                default: ;
            endcase
        end
    end

    assign acc    = acc_r;
    assign flags  = {c_flag, z_flag};
    assign halted = (state == ST_HALT);

endmodule

// File: tb/tb_accu_core_p.sv
// Directed bench for accu_core_p: ROM-fed programs with hand-computed expectations.
module tb_accu_core_p;

    localparam logic [4:0] NOP  = 5'h00, LDI = 5'h01, LDR = 5'h02, STR = 5'h03;
    localparam logic [4:0] LDM  = 5'h04, STM = 5'h05, ADC = 5'h07, SUB = 5'h08;
    localparam logic [4:0] ADDI = 5'h0C, JMP = 5'h0D, JZ = 5'h0E, JC = 5'h0F;
    localparam logic [4:0] CALL = 5'h10, RET = 5'h11, HLT = 5'h12;

    logic        clk = 1'b0;
    logic        nReset = 1'b0;
    logic [5:0]  pc;
    logic [12:0] ins;
    logic        dm_req, dm_we;
    logic [7:0]  dm_addr, dm_wdata;
    logic [7:0]  dm_rdata = 8'h00;
    logic        dm_ack = 1'b0;
    logic [7:0]  acc;
    logic [1:0]  flags;
    logic        halted, err;

    logic [12:0] rom [64];
    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;
    assign ins = rom[pc];

    accu_core_p #(
        .DATA_W(8), .PC_W(6), .REG_N(16), .STACK_DEPTH(4), .INS_W(13)
    ) dut (
        .clk(clk), .nReset(nReset), .pc(pc), .ins(ins),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .acc(acc), .flags(flags), .halted(halted), .err(err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 64; i++) rom[i] = {NOP, 8'h00};
    endtask

    task automatic do_reset();
        nReset = 1'b0;
        step(1);
        nReset = 1'b1;
    endtask

    initial begin
        // ALU basics
        clear_rom();
        rom[0] = {LDI, 8'hF0};
        rom[1] = {ADDI, 8'h20};
        rom[2] = {STR, 8'h00};
        rom[3] = {SUB, 8'h00};
        do_reset();
        check("rst_pc", pc, 0);
        check("rst_acc", acc, 0);
        check("rst_flags", flags, 0);
        check("rst_req", dm_req, 0);
        check("rst_halted", halted, 0);
        check("rst_err", err, 0);
        step(2);
        check("addi_acc", acc, 8'h10);
        check("addi_flags", flags, 2'b10);
        check("addi_pc", pc, 2);
        step(2);
        check("sub_acc", acc, 8'h00);
        check("sub_flags", flags, 2'b01);
        check("sub_pc", pc, 4);

        // registers and carry-in
        clear_rom();
        rom[0] = {LDI, 8'hFF};
        rom[1] = {STR, 8'h05};
        rom[2] = {ADDI, 8'h01};
        rom[3] = {ADC, 8'h05};
        rom[4] = {LDR, 8'h05};
        do_reset();
        step(3);
        check("addi_wrap_acc", acc, 8'h00);
        check("addi_wrap_flags", flags, 2'b11);
        step(1);
        check("adc_acc", acc, 8'h00);
        check("adc_flags", flags, 2'b11);
        step(1);
        check("ldr_acc", acc, 8'hFF);
        check("ldr_flags", flags, 2'b10);

        // memory stall then zero-wait load
        clear_rom();
        rom[0] = {LDI, 8'h5A};
        rom[1] = {STM, 8'h12};
        rom[2] = {LDI, 8'h00};
        rom[3] = {LDM, 8'h12};
        do_reset();
        step(2);
        for (int i = 0; i < 4; i++) begin
            check("stm_req", dm_req, 1);
            check("stm_we", dm_we, 1);
            check("stm_addr", dm_addr, 8'h12);
            check("stm_wdata", dm_wdata, 8'h5A);
            check("stm_pc", pc, 1);
            if (i == 3) dm_ack = 1'b1;
            step(1);
            dm_ack = 1'b0;
        end
        check("stm_done_req", dm_req, 0);
        check("stm_done_pc", pc, 2);
        check("stm_done_acc", acc, 8'h5A);
        step(1);
        check("ldi0_flags", flags, 2'b01);
        step(1);
        check("ldm_req", dm_req, 1);
        check("ldm_we", dm_we, 0);
        check("ldm_addr", dm_addr, 8'h12);
        dm_ack = 1'b1;
        dm_rdata = 8'h5A;
        step(1);
        dm_ack = 1'b0;
        check("ldm_acc", acc, 8'h5A);
        check("ldm_req_off", dm_req, 0);
        check("ldm_pc", pc, 4);
        check("ldm_flags", flags, 2'b00);

        // branches and pc wrap
        clear_rom();
        rom[0]     = {JZ, 8'h20};
        rom[1]     = {LDI, 8'h01};
        rom[2]     = {ADDI, 8'hFF};
        rom[3]     = {JC, 8'h20};
        rom[6'h20] = {JMP, 8'h3F};
        do_reset();
        step(1);
        check("jz_not_taken", pc, 1);
        step(2);
        check("c_set_flags", flags, 2'b11);
        step(1);
        check("jc_taken", pc, 6'h20);
        step(1);
        check("jmp_pc", pc, 6'h3F);
        step(1);
        check("pc_wrap", pc, 0);

        // nested calls, LIFO returns, push of wrapped pc
        clear_rom();
        rom[0]     = {CALL, 8'h10};
        rom[6'h10] = {CALL, 8'h20};
        rom[6'h20] = {CALL, 8'h30};
        rom[6'h30] = {CALL, 8'h38};
        rom[6'h38] = {RET, 8'h00};
        rom[6'h31] = {RET, 8'h00};
        rom[6'h21] = {RET, 8'h00};
        rom[6'h11] = {RET, 8'h00};
        rom[1]     = {JMP, 8'h3F};
        rom[6'h3F] = {CALL, 8'h3E};
        rom[6'h3E] = {RET, 8'h00};
        do_reset();
        step(4);
        check("call4_pc", pc, 6'h38);
        check("call4_err", err, 0);
        step(1);
        check("ret1_pc", pc, 6'h31);
        step(1);
        check("ret2_pc", pc, 6'h21);
        step(1);
        check("ret3_pc", pc, 6'h11);
        step(1);
        check("ret4_pc", pc, 6'h01);
        step(2);
        check("call_wrap_pc", pc, 6'h3E);
        step(1);
        check("ret_wrap_pc", pc, 6'h00);
        check("lifo_err", err, 0);

        // stack overflow on fifth CALL
        clear_rom();
        rom[0]     = {CALL, 8'h08};
        rom[6'h08] = {CALL, 8'h10};
        rom[6'h10] = {CALL, 8'h18};
        rom[6'h18] = {CALL, 8'h20};
        rom[6'h20] = {CALL, 8'h28};
        do_reset();
        step(4);
        check("pre_ovf_pc", pc, 6'h20);
        check("pre_ovf_halted", halted, 0);
        step(1);
        check("ovf_err", err, 1);
        check("ovf_halted", halted, 1);
        check("ovf_pc", pc, 6'h20);
        step(3);
        check("ovf_pc_hold", pc, 6'h20);
        check("ovf_err_sticky", err, 1);

        // underflow on RET with empty stack
        clear_rom();
        rom[0] = {RET, 8'h00};
        do_reset();
        check("unf_err_cleared", err, 0);
        step(1);
        check("unf_err", err, 1);
        check("unf_halted", halted, 1);
        check("unf_pc", pc, 0);

        // reset during MEM_WAIT, stray ack, HALT
        clear_rom();
        rom[0] = {LDI, 8'h33};
        rom[1] = {LDM, 8'h05};
        do_reset();
        step(2);
        check("mw_req", dm_req, 1);
        check("mw_acc", acc, 8'h33);
        nReset = 1'b0;
        step(1);
        check("mrst_req", dm_req, 0);
        check("mrst_pc", pc, 0);
        check("mrst_acc", acc, 0);
        rom[0] = {NOP, 8'h00};
        rom[1] = {NOP, 8'h00};
        rom[2] = {HLT, 8'h00};
        nReset = 1'b1;
        dm_ack = 1'b1;
        dm_rdata = 8'h77;
        step(2);
        dm_ack = 1'b0;
        check("stray_ack_acc", acc, 0);
        check("stray_ack_pc", pc, 2);
        check("stray_ack_req", dm_req, 0);
        step(1);
        check("halt_halted", halted, 1);
        check("halt_pc", pc, 2);
        step(10);
        check("halt_pc_frozen", pc, 2);
        check("halt_still", halted, 1);
        check("halt_no_err", err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1);
    end

endmodule
